// File: rtl/q2_pkg.sv
// Shared constants and types for the Q2 register slice.
package q2_pkg;

   // Default datapath and state-register widths.
   localparam int Q2_WIDTH  = 12;
   localparam int Q2_SWIDTH = 4;

   // X register load source.
   typedef enum logic [1:0] {
      XSEL_ZERO  = 2'd0,
      XSEL_SHIFT = 2'd1,
      XSEL_P     = 2'd2,
      XSEL_DBUS  = 2'd3
   } xsel_t;

   // Two drivers requested on the same bus in the same cycle.
   function automatic logic bus_conflict(input logic req_a, input logic req_b);
      return req_a & req_b;
   endfunction

endpackage

// File: rtl/q2_pc_reg.sv
// Program counter: reset-to-switches, load from X, increment with wrap pulse.
module q2_pc_reg #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             wrp,
   input  logic             incp,
   input  logic [WIDTH-1:0] x_val,
   output logic [WIDTH-1:0] pout,
   output logic             pwrap
);

   logic [WIDTH-1:0] p_reg;
   logic [WIDTH-1:0] p_next;
   logic             pwrap_reg;
   logic             pwrap_next;

   // Next P: a load beats an increment; the wrap pulse only comes from an increment.
   always_comb begin
      p_next     = p_reg;
      pwrap_next = 1'b0;
      if (wrp) begin
         p_next = x_val;
      end else if (incp) begin
         p_next     = p_reg + WIDTH'(1);
         pwrap_next = &p_reg;
      end
   end

   // P register and wrap pulse; reset loads the front-panel switches.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_reg     <= sw;
         pwrap_reg <= 1'b0;
      end else begin
         p_reg     <= p_next;
         pwrap_reg <= pwrap_next;
      end
   end

   assign pout  = p_reg;
   assign pwrap = pwrap_reg;

endmodule

// File: rtl/q2_regs.sv
// Q2 datapath registers (A, X, P, S) with muxed A/D bus drive and conflict flag.
module q2_regs
   import q2_pkg::*;
#(
   parameter int WIDTH  = Q2_WIDTH,
   parameter int SWIDTH = Q2_SWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  sw,
   input  logic              dep,
   input  logic [WIDTH-1:0]  dbus_in,
   output logic [WIDTH-1:0]  dbus_out,
   output logic              dbus_oe,
   output logic [WIDTH-1:0]  abus_out,
   output logic              abus_oe,
   input  logic [WIDTH-1:0]  ain,
   input  logic              wra,
   input  logic              rda,
   input  logic              incp,
   input  logic              wrp,
   input  logic              rdp,
   input  logic              wrx,
   input  logic              rdx,
   input  logic [1:0]        xsel,
   input  logic              xshift_in,
   input  logic [SWIDTH-1:0] sin,
   input  logic              wrs,
   input  logic              rsts,
   output logic [WIDTH-1:0]  aout,
   output logic [WIDTH-1:0]  xout,
   output logic [WIDTH-1:0]  pout,
   output logic [SWIDTH-1:0] sout,
   output logic              pwrap,
   output logic              bus_err
);

   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  a_next;
   logic [WIDTH-1:0]  x_reg;
   logic [WIDTH-1:0]  x_next;
   logic [SWIDTH-1:0] s_reg;
   logic [SWIDTH-1:0] s_next;
   logic              err_reg;
   logic              err_next;
   logic [WIDTH-1:0]  p_val;
   logic              conflict;

   // P lives in its own block; it sees the pre-edge X so wrp+wrx swaps cleanly.
   q2_pc_reg #(
      .WIDTH (WIDTH)
   ) u_pc (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw),
      .wrp   (wrp),
      .incp  (incp),
      .x_val (x_reg),
      .pout  (p_val),
      .pwrap (pwrap)
   );

   // A takes the ALU result when strobed.
   always_comb begin
      a_next = a_reg;
      if (wra) begin
         a_next = ain;
      end
   end

   // X source select; the P source is the pre-edge P so xsel=P with wrp swaps.
   always_comb begin
      x_next = x_reg;
      if (wrx) begin
         case (xsel_t'(xsel))
            XSEL_ZERO:  x_next = '0;
            XSEL_SHIFT: x_next = {x_reg[WIDTH-2:0], xshift_in};
            XSEL_P:     x_next = p_val;
            XSEL_DBUS:  x_next = dbus_in;
            default:    x_next = x_reg;
         endcase
      end
   end

   // S: clear beats load.
   always_comb begin
      s_next = s_reg;
      if (rsts) begin
         s_next = '0;
      end else if (wrs) begin
         s_next = sin;
      end
   end

   // Conflict flag is sticky: once set only reset clears it.
   always_comb begin
      conflict = bus_conflict(rda, dep) | bus_conflict(rdx, rdp);
      err_next = err_reg | conflict;
   end

   // Datapath state; strobes are ignored while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg   <= '0;
         x_reg   <= '0;
         s_reg   <= '0;
         err_reg <= 1'b0;
      end else begin
         a_reg   <= a_next;
         x_reg   <= x_next;
         s_reg   <= s_next;
         err_reg <= err_next;
      end
   end

   // Bus drive values per bit: the higher-priority source wins during a conflict,
   // and an undriven bus reads as zero.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bus
         assign dbus_out[gi] = rda ? a_reg[gi] : (dep & sw[gi]);
         assign abus_out[gi] = rdx ? x_reg[gi] : (rdp & p_val[gi]);
      end
   endgenerate

   assign dbus_oe = rda | dep;
   assign abus_oe = rdx | rdp;

   assign aout    = a_reg;
   assign xout    = x_reg;
   assign pout    = p_val;
   assign sout    = s_reg;
   assign bus_err = err_reg;

endmodule

// File: tb/tb_q2_regs.sv
// Directed bench for q2_regs: stimulus queues hand-computed expectations,
// a monitor pops and compares them each cycle.
module tb_q2_regs;

   localparam int W  = 12;
   localparam int SW = 4;

   logic          clk;
   logic          rst;
   logic [W-1:0]  sw;
   logic          dep;
   logic [W-1:0]  dbus_in;
   logic [W-1:0]  dbus_out;
   logic          dbus_oe;
   logic [W-1:0]  abus_out;
   logic          abus_oe;
   logic [W-1:0]  ain;
   logic          wra;
   logic          rda;
   logic          incp;
   logic          wrp;
   logic          rdp;
   logic          wrx;
   logic          rdx;
   logic [1:0]    xsel;
   logic          xshift_in;
   logic [SW-1:0] sin;
   logic          wrs;
   logic          rsts;
   logic [W-1:0]  aout;
   logic [W-1:0]  xout;
   logic [W-1:0]  pout;
   logic [SW-1:0] sout;
   logic          pwrap;
   logic          bus_err;

   q2_regs #(
      .WIDTH  (W),
      .SWIDTH (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .dep       (dep),
      .dbus_in   (dbus_in),
      .dbus_out  (dbus_out),
      .dbus_oe   (dbus_oe),
      .abus_out  (abus_out),
      .abus_oe   (abus_oe),
      .ain       (ain),
      .wra       (wra),
      .rda       (rda),
      .incp      (incp),
      .wrp       (wrp),
      .rdp       (rdp),
      .wrx       (wrx),
      .rdx       (rdx),
      .xsel      (xsel),
      .xshift_in (xshift_in),
      .sin       (sin),
      .wrs       (wrs),
      .rsts      (rsts),
      .aout      (aout),
      .xout      (xout),
      .pout      (pout),
      .sout      (sout),
      .pwrap     (pwrap),
      .bus_err   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Which DUT output an expectation refers to.
   typedef enum int {
      O_A, O_X, O_P, O_S, O_PWRAP, O_ERR, O_DOUT, O_DOE, O_AOUT, O_AOE
   } osel_t;

   typedef struct {
      string    name;
      osel_t    sel;
      logic [W-1:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic expect_out(input string name, input osel_t sel, input logic [W-1:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Advance to the next cycle window and release every strobe.
   task automatic next_cycle();
      @(negedge clk);
      rst  = 1'b0; dep = 1'b0; wra = 1'b0; rda = 1'b0; incp = 1'b0;
      wrp  = 1'b0; rdp = 1'b0; wrx = 1'b0; rdx = 1'b0; wrs = 1'b0; rsts = 1'b0;
   endtask

   // Monitor: shortly after each falling edge, drain and check the expectations
   // queued for the current cycle window.
   initial begin
      exp_t         e;
      logic [W-1:0] act;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
               O_A:     act = aout;
               O_X:     act = xout;
               O_P:     act = pout;
               O_S:     act = W'(sout);
               O_PWRAP: act = W'(pwrap);
               O_ERR:   act = W'(bus_err);
               O_DOUT:  act = dbus_out;
               O_DOE:   act = W'(dbus_oe);
               O_AOUT:  act = abus_out;
               O_AOE:   act = W'(abus_oe);
               default: act = 'x;
            endcase
            n_vec++;
            if (act !== e.val) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end else begin
               $display("ok   %s: %h", e.name, act);
            end
         end
      end
   end

   // Stimulus with hand-computed expectations of the pre-edge state and buses.
   initial begin
      rst = 1'b1; sw = 12'hA5C; dep = 1'b0; dbus_in = '0; ain = '0;
      wra = 1'b0; rda = 1'b0; incp = 1'b0; wrp = 1'b0; rdp = 1'b0;
      wrx = 1'b0; rdx = 1'b0; xsel = 2'd0; xshift_in = 1'b0;
      sin = '0; wrs = 1'b0; rsts = 1'b0;

      // Reset state.
      next_cycle();
      expect_out("rst_a",     O_A,     12'h000);
      expect_out("rst_x",     O_X,     12'h000);
      expect_out("rst_p",     O_P,     12'hA5C);
      expect_out("rst_s",     O_S,     12'h000);
      expect_out("rst_pwrap", O_PWRAP, 12'h000);
      expect_out("rst_err",   O_ERR,   12'h000);
      expect_out("rst_doe",   O_DOE,   12'h000);
      expect_out("rst_dout",  O_DOUT,  12'h000);
      expect_out("rst_aoe",   O_AOE,   12'h000);
      expect_out("rst_aout",  O_AOUT,  12'h000);

      // Increment across the wrap.
      next_cycle(); rst = 1'b1; sw = 12'hFFE;
      next_cycle(); incp = 1'b1;
      expect_out("inc_p0", O_P, 12'hFFE);
      next_cycle(); incp = 1'b1;
      expect_out("inc_p1",     O_P,     12'hFFF);
      expect_out("inc_pwrap1", O_PWRAP, 12'h000);
      next_cycle(); incp = 1'b1;
      expect_out("inc_p2",     O_P,     12'h000);
      expect_out("inc_pwrap2", O_PWRAP, 12'h001);
      next_cycle();
      expect_out("inc_p3",     O_P,     12'h001);
      expect_out("inc_pwrap3", O_PWRAP, 12'h000);

      // X sources.
      xsel = 2'd3; dbus_in = 12'h801; wrx = 1'b1;
      next_cycle(); xsel = 2'd1; xshift_in = 1'b1; wrx = 1'b1;
      expect_out("x_dbus", O_X, 12'h801);
      next_cycle(); xsel = 2'd1; wrx = 1'b1;
      expect_out("x_shift1", O_X, 12'h003);
      next_cycle(); xsel = 2'd0; wrx = 1'b1;
      expect_out("x_shift2", O_X, 12'h007);
      next_cycle(); xsel = 2'd3; dbus_in = 12'h123; wrx = 1'b1;
      expect_out("x_zero", O_X, 12'h000);

      // Set up P=123, X=456, then swap with a dropped increment.
      next_cycle(); wrp = 1'b1;
      expect_out("x_123", O_X, 12'h123);
      next_cycle(); xsel = 2'd3; dbus_in = 12'h456; wrx = 1'b1;
      expect_out("p_load", O_P, 12'h123);
      next_cycle(); wrp = 1'b1; wrx = 1'b1; incp = 1'b1; xsel = 2'd2;
      expect_out("pre_swap_x", O_X, 12'h456);
      expect_out("pre_swap_p", O_P, 12'h123);

      // S clear priority over load.
      next_cycle(); rsts = 1'b1; wrs = 1'b1; sin = 4'hF;
      expect_out("swap_p",     O_P,     12'h456);
      expect_out("swap_x",     O_X,     12'h123);
      expect_out("swap_pwrap", O_PWRAP, 12'h000);
      next_cycle(); wrs = 1'b1;
      expect_out("s_clr", O_S, 12'h000);
      next_cycle(); wra = 1'b1; ain = 12'h0F0;
      expect_out("s_load", O_S, 12'h00F);

      // D bus drive and conflict.
      next_cycle(); rda = 1'b1;
      expect_out("a_load",   O_A,    12'h0F0);
      expect_out("rda_doe",  O_DOE,  12'h001);
      expect_out("rda_dout", O_DOUT, 12'h0F0);
      expect_out("rda_err",  O_ERR,  12'h000);
      next_cycle(); rda = 1'b1; dep = 1'b1; sw = 12'h111;
      expect_out("dconf_dout", O_DOUT, 12'h0F0);
      expect_out("dconf_doe",  O_DOE,  12'h001);
      expect_out("dconf_err0", O_ERR,  12'h000);
      next_cycle();
      expect_out("dconf_err1", O_ERR,  12'h001);
      expect_out("idle_doe",   O_DOE,  12'h000);
      expect_out("idle_dout",  O_DOUT, 12'h000);
      next_cycle(); dep = 1'b1;
      expect_out("dep_dout",  O_DOUT, 12'h111);
      expect_out("dep_doe",   O_DOE,  12'h001);
      expect_out("err_stick", O_ERR,  12'h001);

      // A bus drive.
      next_cycle(); rdx = 1'b1;
      expect_out("rdx_aout", O_AOUT, 12'h123);
      expect_out("rdx_aoe",  O_AOE,  12'h001);
      next_cycle(); rdp = 1'b1;
      expect_out("rdp_aout", O_AOUT, 12'h456);
      expect_out("rdp_aoe",  O_AOE,  12'h001);
      next_cycle(); rdx = 1'b1; rdp = 1'b1;
      expect_out("aconf_aout", O_AOUT, 12'h123);

      // Reset mid-operation with strobes active.
      next_cycle(); rst = 1'b1; incp = 1'b1; wra = 1'b1; ain = 12'hFFF; sw = 12'h321;
      next_cycle(); rdx = 1'b1; rdp = 1'b1;
      expect_out("mid_rst_p",     O_P,     12'h321);
      expect_out("mid_rst_a",     O_A,     12'h000);
      expect_out("mid_rst_x",     O_X,     12'h000);
      expect_out("mid_rst_err",   O_ERR,   12'h000);
      expect_out("mid_rst_pwrap", O_PWRAP, 12'h000);
      expect_out("aconf_aout2",   O_AOUT,  12'h000);

      // Fresh A-bus conflict sets the flag again.
      next_cycle();
      expect_out("aconf_err", O_ERR, 12'h001);
      expect_out("idle_aoe",  O_AOE, 12'h000);

      next_cycle();
      next_cycle();
      if (exp_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
